// File: rtl/wb_pkg.sv
// Shared types and sizing for the writeback arbiter and its picker.
package wb_pkg;

   localparam int TAG_WIDTH_DEF  = 6;
   localparam int DATA_WIDTH_DEF = 32;
   localparam int NUM_SRC_MAX    = 8;
   localparam int PTR_W          = $clog2(NUM_SRC_MAX);

   typedef struct packed {
      logic                      en;
      logic [TAG_WIDTH_DEF-1:0]  tag;
      logic [DATA_WIDTH_DEF-1:0] data;
   } wb_slot_t;

endpackage

// File: rtl/wb_write_arbiter_2w_rr_pick2.sv
// Combinational two-winner round-robin picker. The second winner must carry
// a tag that differs from the first winner's tag.
import wb_pkg::*;

module rr_pick2 #(
   parameter int NUM_SRC   = 4,
   parameter int TAG_WIDTH = 6
) (
   input  logic [NUM_SRC-1:0]           valid,
   input  logic [NUM_SRC*TAG_WIDTH-1:0] tags,
   input  logic [PTR_W-1:0]             ptr,
   output logic [NUM_SRC-1:0]           grant1,
   output logic [NUM_SRC-1:0]           grant2,
   output logic [PTR_W-1:0]             idx1,
   output logic [PTR_W-1:0]             idx2,
   output logic                         found1,
   output logic                         found2
);

   logic [TAG_WIDTH-1:0] tag1;
   logic [TAG_WIDTH-1:0] cur_tag;
   int                   j;

   always_comb begin
      grant1  = '0;
      grant2  = '0;
      idx1    = '0;
      idx2    = '0;
      found1  = 1'b0;
      found2  = 1'b0;
      tag1    = '0;
      cur_tag = '0;
      j       = 0;
      for (int k = 0; k < NUM_SRC; k++) begin
         j = int'(ptr) + k;
         if (j >= NUM_SRC) j = j - NUM_SRC;
         cur_tag = tags[j*TAG_WIDTH +: TAG_WIDTH];
         if (valid[j]) begin
            if (!found1) begin
               found1    = 1'b1;
               idx1      = PTR_W'(j);
               tag1      = cur_tag;
               grant1[j] = 1'b1;
            end else if (!found2 && cur_tag != tag1) begin
               found2    = 1'b1;
               idx2      = PTR_W'(j);
               grant2[j] = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/wb_write_arbiter_2w.sv
// Writeback arbiter: grants up to two FU results per cycle and drives the
// registered two-port register-file write plus the matching wakeup vector.
import wb_pkg::*;

module wb_write_arbiter_2w #(
   parameter int NUM_SRC    = 4,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int TAG_WIDTH  = TAG_WIDTH_DEF,
   parameter int DROP_ZERO  = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          flush_i,
   input  logic [NUM_SRC-1:0]            src_valid_i,
   input  logic [NUM_SRC*TAG_WIDTH-1:0]  src_tag_i,
   input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data_i,
   output logic [NUM_SRC-1:0]            src_ready_o,
   output logic                          wr1_en_o,
   output logic [TAG_WIDTH-1:0]          wr1_tag_o,
   output logic [DATA_WIDTH-1:0]         wr1_data_o,
   output logic                          wr2_en_o,
   output logic [TAG_WIDTH-1:0]          wr2_tag_o,
   output logic [DATA_WIDTH-1:0]         wr2_data_o,
   output logic [1:0]                    wake_vec_o
);

   logic [PTR_W-1:0]      rr_ptr_reg, rr_ptr_next;
   logic [NUM_SRC-1:0]    grant1, grant2;
   logic [PTR_W-1:0]      idx1, idx2;
   logic                  found1, found2;
   logic                  block;
   logic [TAG_WIDTH-1:0]  tag1, tag2;
   logic [DATA_WIDTH-1:0] data1, data2;
   logic                  live1, live2;
   logic                  p1_en_next, p2_en_next;
   logic [TAG_WIDTH-1:0]  p1_tag_next, p2_tag_next;
   logic [DATA_WIDTH-1:0] p1_data_next, p2_data_next;
   int                    last_idx;

   rr_pick2 #(.NUM_SRC(NUM_SRC), .TAG_WIDTH(TAG_WIDTH)) u_pick (
      .valid  (src_valid_i),
      .tags   (src_tag_i),
      .ptr    (rr_ptr_reg),
      .grant1 (grant1),
      .grant2 (grant2),
      .idx1   (idx1),
      .idx2   (idx2),
      .found1 (found1),
      .found2 (found2)
   );

   assign block       = rst | flush_i;
   assign src_ready_o = block ? '0 : (grant1 | grant2);

   assign tag1  = src_tag_i[int'(idx1)*TAG_WIDTH +: TAG_WIDTH];
   assign tag2  = src_tag_i[int'(idx2)*TAG_WIDTH +: TAG_WIDTH];
   assign data1 = src_data_i[int'(idx1)*DATA_WIDTH +: DATA_WIDTH];
   assign data2 = src_data_i[int'(idx2)*DATA_WIDTH +: DATA_WIDTH];

   // Tag-0 results are consumed but never written; a live slot2 slides to port 1.
   assign live1 = found1 && !(DROP_ZERO != 0 && tag1 == '0);
   assign live2 = found2 && !(DROP_ZERO != 0 && tag2 == '0);

   always_comb begin
      p1_en_next   = live1 | live2;
      p1_tag_next  = live1 ? tag1 : tag2;
      p1_data_next = live1 ? data1 : data2;
      p2_en_next   = live1 & live2;
      p2_tag_next  = tag2;
      p2_data_next = data2;
      last_idx     = found2 ? int'(idx2) : int'(idx1);
      rr_ptr_next  = rr_ptr_reg;
      if (found1)
         rr_ptr_next = (last_idx + 1 >= NUM_SRC) ? '0 : PTR_W'(last_idx + 1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_reg <= '0;
         wr1_en_o   <= 1'b0;
         wr1_tag_o  <= '0;
         wr1_data_o <= '0;
         wr2_en_o   <= 1'b0;
         wr2_tag_o  <= '0;
         wr2_data_o <= '0;
      end else if (flush_i) begin
         rr_ptr_reg <= '0;
         wr1_en_o   <= 1'b0;
         wr2_en_o   <= 1'b0;
      end else begin
         rr_ptr_reg <= rr_ptr_next;
         wr1_en_o   <= p1_en_next;
         wr2_en_o   <= p2_en_next;
         if (p1_en_next) begin
            wr1_tag_o  <= p1_tag_next;
            wr1_data_o <= p1_data_next;
         end
         if (p2_en_next) begin
            wr2_tag_o  <= p2_tag_next;
            wr2_data_o <= p2_data_next;
         end
      end
   end

   assign wake_vec_o = {wr2_en_o, wr1_en_o};

endmodule
